// File: rtl/clock_set_controller.sv
// clock_set_controller
//   Hours:minutes timekeeping for the wall clock plus the button-driven
//   time-set sequencer. The minute count advances on min_tick while running.
//   Two debounced buttons step through the set modes and increment the
//   selected field. Leaving set mode issues tick_clr, which re-phases the
//   upstream minute-enable counter.
//
//   Optional feature macro: CLOCK_SET_AUTO_REPEAT_EN
//     defined   -> a held btn_inc auto-repeats (HOLD_DELAY, then every REPEAT_PERIOD)
//     undefined -> exactly one increment per btn_inc rising edge
//
// Ports
//   ck        in   system clock, rising edge
//   reset     in   synchronous active-low reset
//   min_tick  in   one-cycle pulse per minute
//   btn_mode  in   debounced mode button (level)
//   btn_inc   in   debounced increment button (level)
//   hours     out  [4:0] 0..23
//   minutes   out  [5:0] 0..59
//   mode      out  [1:0] 0 RUN, 1 SET_HOURS, 2 SET_MINUTES
//   blink     out  blank strobe for the field being set
//   tick_clr  out  one-cycle pulse on SET_MINUTES -> RUN
//
// state          | meaning
// ST_RUN         | time advances on min_tick, btn_inc ignored
// ST_SET_HOURS   | time frozen, increments go to hours
// ST_SET_MINUTES | time frozen, increments go to minutes (no carry)

module clock_set_controller #(
  parameter int HOLD_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD = 20_000_000,
  parameter int BLINK_PERIOD  = 25_000_000,
  parameter int CNT_W         = 27
) (
  input  logic       ck,
  input  logic       reset,
  input  logic       min_tick,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [1:0] mode,
  output logic       blink,
  output logic       tick_clr
);

  typedef enum logic [1:0] {
    ST_RUN         = 2'd0,
    ST_SET_HOURS   = 2'd1,
    ST_SET_MINUTES = 2'd2
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [4:0]         r_hours, w_hours_nxt;
  logic [5:0]         r_minutes, w_minutes_nxt;
  logic               r_blink, w_blink_nxt;
  logic [CNT_W-1:0]   r_blink_cnt, w_blink_cnt_nxt;
  logic               r_tick_clr, w_tick_clr_nxt;
  logic               r_btn_mode_prev, r_btn_inc_prev;
  logic               w_mode_edge, w_inc_edge, w_in_set, w_rpt_evt, w_inc_evt;

`ifdef CLOCK_SET_AUTO_REPEAT_EN
  // Down-counter: 0 = idle, otherwise cycles left until the next repeat event.
  logic [CNT_W-1:0]   r_hold_cnt, w_hold_cnt_nxt;
`else
  logic [CNT_W-1:0]   w_unused_params;
  assign w_unused_params = CNT_W'(HOLD_DELAY) ^ CNT_W'(REPEAT_PERIOD);
`endif

  assign w_mode_edge = btn_mode & ~r_btn_mode_prev;
  assign w_inc_edge  = btn_inc & ~r_btn_inc_prev;
  assign w_in_set    = (r_state != ST_RUN);

`ifdef CLOCK_SET_AUTO_REPEAT_EN
  always_comb begin
    w_rpt_evt      = 1'b0;
    w_hold_cnt_nxt = r_hold_cnt;
    // A mode change or release always drops any pending repeat.
    if (!w_in_set || !btn_inc || w_mode_edge) begin
      w_hold_cnt_nxt = '0;
    end else if (w_inc_edge) begin
      w_hold_cnt_nxt = CNT_W'(HOLD_DELAY);
    end else if (r_hold_cnt == CNT_W'(1)) begin
      w_rpt_evt      = 1'b1;
      w_hold_cnt_nxt = CNT_W'(REPEAT_PERIOD);
    end else if (r_hold_cnt != '0) begin
      w_hold_cnt_nxt = r_hold_cnt - CNT_W'(1);
    end
  end
`else
  assign w_rpt_evt = 1'b0;
`endif

  // Mode change wins over a coincident increment.
  assign w_inc_evt = w_in_set & (w_inc_edge | w_rpt_evt) & ~w_mode_edge;

  always_comb begin
    w_state_nxt     = r_state;
    w_hours_nxt     = r_hours;
    w_minutes_nxt   = r_minutes;
    w_blink_nxt     = r_blink;
    w_blink_cnt_nxt = r_blink_cnt;
    w_tick_clr_nxt  = 1'b0;

    // Blink phase in set modes; overridden below on entry or in RUN.
    if (r_blink_cnt <= CNT_W'(1)) begin
      w_blink_nxt     = ~r_blink;
      w_blink_cnt_nxt = CNT_W'(BLINK_PERIOD);
    end else begin
      w_blink_cnt_nxt = r_blink_cnt - CNT_W'(1);
    end

    case (r_state)
      ST_RUN: begin
        w_blink_nxt     = 1'b0;
        w_blink_cnt_nxt = '0;
        if (min_tick) begin
          if (r_minutes == 6'd59) begin
            w_minutes_nxt = 6'd0;
            w_hours_nxt   = (r_hours == 5'd23) ? 5'd0 : r_hours + 5'd1;
          end else begin
            w_minutes_nxt = r_minutes + 6'd1;
          end
        end
        if (w_mode_edge) begin
          w_state_nxt     = ST_SET_HOURS;
          w_blink_cnt_nxt = CNT_W'(BLINK_PERIOD);
        end
      end
      ST_SET_HOURS: begin
        if (w_mode_edge) begin
          w_state_nxt     = ST_SET_MINUTES;
          w_blink_nxt     = 1'b0;
          w_blink_cnt_nxt = CNT_W'(BLINK_PERIOD);
        end else if (w_inc_evt) begin
          w_hours_nxt = (r_hours == 5'd23) ? 5'd0 : r_hours + 5'd1;
        end
      end
      ST_SET_MINUTES: begin
        if (w_mode_edge) begin
          w_state_nxt     = ST_RUN;
          w_tick_clr_nxt  = 1'b1;
          w_blink_nxt     = 1'b0;
          w_blink_cnt_nxt = '0;
        end else if (w_inc_evt) begin
          w_minutes_nxt = (r_minutes == 6'd59) ? 6'd0 : r_minutes + 6'd1;
        end
      end
      default: begin
        w_state_nxt     = ST_RUN;
        w_blink_nxt     = 1'b0;
        w_blink_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge ck) begin
    if (!reset) begin
      r_state         <= ST_RUN;
      r_hours         <= 5'd0;
      r_minutes       <= 6'd0;
      r_blink         <= 1'b0;
      r_blink_cnt     <= '0;
      r_tick_clr      <= 1'b0;
      // Start high so a button held through reset is not seen as a press.
      r_btn_mode_prev <= 1'b1;
      r_btn_inc_prev  <= 1'b1;
    end else begin
      r_state         <= w_state_nxt;
      r_hours         <= w_hours_nxt;
      r_minutes       <= w_minutes_nxt;
      r_blink         <= w_blink_nxt;
      r_blink_cnt     <= w_blink_cnt_nxt;
      r_tick_clr      <= w_tick_clr_nxt;
      r_btn_mode_prev <= btn_mode;
      r_btn_inc_prev  <= btn_inc;
    end
  end

`ifdef CLOCK_SET_AUTO_REPEAT_EN
  always_ff @(posedge ck) begin
    if (!reset) r_hold_cnt <= '0;
    else        r_hold_cnt <= w_hold_cnt_nxt;
  end
`endif

  assign hours    = r_hours;
  assign minutes  = r_minutes;
  assign mode     = r_state;
  assign blink    = r_blink;
  assign tick_clr = r_tick_clr;

endmodule

// File: doc/clock_set_controller.md
Name: clock_set_controller

Overview:
- Timekeeping and time-set controller for the auto-increment wall clock.
- Consumes the one-cycle minute tick from the minute-enable counter and holds the hours:minutes registers.
- Sequences RUN / SET_HOURS / SET_MINUTES modes from two debounced buttons, with auto-repeat on a held increment button.
- Issues a clear pulse that re-phases the minute-enable counter when the user leaves set mode.

Parameters:
- HOLD_DELAY, 50_000_000: cycles btn_inc must stay high after the first increment before auto-repeat starts (0.5 s at 100 MHz).
- REPEAT_PERIOD, 20_000_000: cycles between auto-repeat increments (0.2 s).
- BLINK_PERIOD, 25_000_000: cycles per blink half-period in set modes.
- CNT_W, 27: width of the internal hold/repeat and blink counters; must hold max(HOLD_DELAY, REPEAT_PERIOD, BLINK_PERIOD).

Ports:
- ck  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-low reset; sampled on rising ck; 0 = reset.
- min_tick  input  1  one-cycle pulse per minute from the minute-enable counter.
- btn_mode  input  1  debounced mode button, level, active-high.
- btn_inc  input  1  debounced increment button, level, active-high.
- hours  output  5  current hours, 0..23, registered.
- minutes  output  6  current minutes, 0..59, registered.
- mode  output  2  0 = RUN, 1 = SET_HOURS, 2 = SET_MINUTES; 3 is never driven.
- blink  output  1  display blank strobe for the field being set; 0 in RUN.
- tick_clr  output  1  one-cycle pulse that clears the minute-enable counter.

Behaviour:
- Reset (reset = 0 at a rising ck):
  - hours = 0, minutes = 0, mode = RUN, blink = 0, tick_clr = 0.
  - Hold and blink counters cleared.
  - Button-previous registers set to 1, so a button held through reset generates no edge.
- Edge detect: mode_edge = btn_mode & ~btn_mode_prev; inc_edge = btn_inc & ~btn_inc_prev. Prev registers update every cycle.
- Action latency: an action caused by a condition sampled at rising edge N is visible in the outputs immediately after edge N.
- Mode FSM, advanced on mode_edge only:
  - RUN -> SET_HOURS -> SET_MINUTES -> RUN.
  - On the SET_MINUTES -> RUN transition, tick_clr = 1 for exactly one cycle. It is 0 at all other times.
- RUN:
  - On min_tick, minutes + 1.
  - At 59 -> 0, hours + 1; hours 23 -> 0.
  - btn_inc is ignored.
- SET_HOURS / SET_MINUTES:
  - min_tick is ignored; time is frozen.
  - Each increment event adds 1 to the selected field only: hours wraps 23 -> 0, minutes wraps 59 -> 0. No carry into hours.
- Increment events in set modes:
  - One event on inc_edge.
  - Auto-repeat (macro enabled): while btn_inc stays high, a further event HOLD_DELAY cycles after the first, then one every REPEAT_PERIOD cycles.
  - Releasing btn_inc clears the hold counter.
- Simultaneous events:
  - mode_edge together with inc_edge or a repeat event: the mode change wins, the increment is dropped, and the hold counter is cleared.
  - The hold counter also clears on every mode change.
- blink:
  - In set modes it toggles every BLINK_PERIOD cycles, starting at 0 on entry to the mode.
  - Forced to 0 and counter cleared in RUN.
- Reset mid-operation, e.g. during auto-repeat or in SET_MINUTES: returns to the reset state on that edge, with no tick_clr pulse.
- All arithmetic is unsigned at field width. Out-of-range values are unreachable.

Optional Feature:
- Macro: CLOCK_SET_AUTO_REPEAT_EN.
- Defined: the hold/repeat counter and auto-repeat events are present, as specified above.
- Undefined: exactly one increment per inc_edge; a held button produces nothing more. The hold counter logic is removed and HOLD_DELAY / REPEAT_PERIOD are unused.

Test Plan:
All scenarios use bench parameters HOLD_DELAY = 8, REPEAT_PERIOD = 4, BLINK_PERIOD = 3.
1. Reset with both buttons held high, then release reset -> hours = 0, minutes = 0, mode = 0, and no increment or mode change until a button falls and rises again.
2. RUN, preload to 23:59 via set modes, return to RUN, pulse min_tick -> 00:00; a further min_tick -> 00:01.
3. Full mode cycle, three btn_mode pulses -> mode sequence 1, 2, 0, with tick_clr high for exactly one cycle at the 2 -> 0 transition; min_tick pulses during modes 1 and 2 leave the time unchanged.
4. SET_MINUTES at 58, btn_inc held for 20 cycles (macro enabled) -> increments at cycles 0, 8, 12, 16 giving 59, 0, 1, 2, with hours unchanged. Same stimulus with the macro disabled -> single increment to 59.
5. SET_HOURS, btn_mode and btn_inc rise on the same cycle -> mode = 2 and hours unchanged. blink toggles at 3-cycle intervals in set modes and is held at 0 in RUN.
6. Reset asserted during auto-repeat in SET_HOURS -> next cycle is the full reset state, with tick_clr = 0 throughout.
